// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by decode, write-back mux and the register file.
package regfile_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 3'd0;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == ZERO_REG;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write-back.
// Optional REGFILE_BYPASS_EN hides busy for a register being written this cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              ren_a,
    input  logic              ren_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall
);
    localparam int NUM_REG = 2 ** ADDR_W;

    logic [NUM_REG-1:0] busy_r;
    logic               wr_hit_s;
    logic               iss_hit_s;
    logic               busy_a_s;
    logic               busy_b_s;

    assign wr_hit_s  = we && (waddr != ADDR_W'(ZERO_REG));
    assign iss_hit_s = issue && (issue_addr != ADDR_W'(ZERO_REG));

    // Busy vector update; the issue assignment comes last so a same-edge set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NUM_REG{1'b0}};
        end else begin
            if (wr_hit_s) begin
                busy_r[waddr] <= 1'b0;
            end
            if (iss_hit_s) begin
                busy_r[issue_addr] <= 1'b1;
            end
        end
    end

    // Per-port busy lookup, optionally masked by a same-cycle write-back to that register.
    always_comb begin
        busy_a_s = busy_r[raddr_a];
        busy_b_s = busy_r[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_hit_s && (raddr_a == waddr) && !(iss_hit_s && (issue_addr == waddr))) begin
            busy_a_s = 1'b0;
        end else begin
            busy_a_s = busy_r[raddr_a];
        end
        if (rst_n && wr_hit_s && (raddr_b == waddr) && !(iss_hit_s && (issue_addr == waddr))) begin
            busy_b_s = 1'b0;
        end else begin
            busy_b_s = busy_r[raddr_b];
        end
`endif
    end

    assign busy_a = busy_a_s;
    assign busy_b = busy_b_s;
    assign stall  = (ren_a && busy_a_s) || (ren_b && busy_b_s);
endmodule

// File: rtl/register_file.sv
// Eight-entry register file with r0 tied to zero, two combinational read ports and a scoreboard.
// Define REGFILE_BYPASS_EN to forward the write-back word to matching read ports in the same cycle.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              ren_a,
    input  logic              ren_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall
);
    localparam int NUM_REG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NUM_REG];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic              wr_hit_s;

    assign wr_hit_s = we && (waddr != ADDR_W'(ZERO_REG));

    // Storage array; entry 0 is only ever loaded with zero so r0 reads back as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_hit_s) begin
                regs_r[waddr] <= wdata;
            end
        end
    end

    // Read muxes; bypass is gated by rst_n so outputs stay zero throughout reset.
    always_comb begin
        rd_a_s = regs_r[raddr_a];
        rd_b_s = regs_r[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_hit_s && (raddr_a == waddr)) begin
            rd_a_s = wdata;
        end else begin
            rd_a_s = regs_r[raddr_a];
        end
        if (rst_n && wr_hit_s && (raddr_b == waddr)) begin
            rd_b_s = wdata;
        end else begin
            rd_b_s = regs_r[raddr_b];
        end
`endif
    end

    assign rdata_a = rd_a_s;
    assign rdata_b = rd_b_s;

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .issue     (issue),
        .issue_addr(issue_addr),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .ren_a     (ren_a),
        .ren_b     (ren_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .stall     (stall)
    );
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hazard sequences, random vs. model.
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = 3'd0;
    logic [15:0] wdata = 16'h0000;
    logic [2:0]  raddr_a = 3'd0;
    logic [2:0]  raddr_b = 3'd0;
    logic        ren_a = 1'b0;
    logic        ren_b = 1'b0;
    logic        issue = 1'b0;
    logic [2:0]  issue_addr = 3'd0;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        busy_a;
    logic        busy_b;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic        m_busy [8];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        ena;
        logic        enb;
        logic        iss;
        logic [2:0]  ia;
        logic [15:0] xa;
        logic [15:0] xb;
        logic        ba;
        logic        bb;
        logic        st;
    } vec_t;

    vec_t tbl [13];

    register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .ren_a     (ren_a),
        .ren_b     (ren_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .issue     (issue),
        .issue_addr(issue_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic ea,
                         input logic eb, input logic is, input logic [2:0] ia);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        ren_a = ea; ren_b = eb; issue = is; issue_addr = ia;
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] ra);
        if (!rst_n) return 16'h0000;
        if (BYP && we && waddr != 3'd0 && ra == waddr) return wdata;
        return (ra == 3'd0) ? 16'h0000 : m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [2:0] ra);
        if (!rst_n || ra == 3'd0) return 1'b0;
        if (BYP && we && waddr != 3'd0 && ra == waddr && !(issue && issue_addr == waddr))
            return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end
    endtask

    // Reference update for one rising edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst_n) begin
            if (we && waddr != 3'd0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (issue && issue_addr != 3'd0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ea, eb, bx, by;
        model_reset();

        // Reset asserted in the middle of a write cycle to r3.
        rst_n = 1'b1;
        tick();
        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_during_rdata_a", rdata_a, 16'h0000);
        chk("rst_during_busy_a", {15'd0, busy_a}, 16'h0000);
        chk("rst_during_stall", {15'd0, stall}, 16'h0000);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
        #1;
        chk("rst_after_rdata_a", rdata_a, 16'h0000);
        chk("rst_after_busy_b", {15'd0, busy_b}, 16'h0000);
        chk("rst_after_stall", {15'd0, stall}, 16'h0000);
        tick();

        //           we    wa    wd        ra    rb    ena   enb   iss   ia    xa        xb        ba    bb    st
        tbl[0]  = '{1'b1, 3'd1, 16'h0001, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 16'h0002, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd3, 16'h0003, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd4, 16'h0004, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd7, 1'b0, 1'b0, 1'b1, 3'd7, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'd6, 16'hABCD, 3'd7, 3'd5, 1'b1, 1'b1, 1'b1, 3'd6, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 1'b1, 1'b0, 1'b0, 3'd0, 16'hABCD, 16'h0000, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb,
                  tbl[i].ena, tbl[i].enb, tbl[i].iss, tbl[i].ia);
            #1;
            chk($sformatf("vec%0d_rdata_a", i), rdata_a, tbl[i].xa);
            chk($sformatf("vec%0d_rdata_b", i), rdata_b, tbl[i].xb);
            chk($sformatf("vec%0d_busy_a", i), {15'd0, busy_a}, {15'd0, tbl[i].ba});
            chk($sformatf("vec%0d_busy_b", i), {15'd0, busy_b}, {15'd0, tbl[i].bb});
            chk($sformatf("vec%0d_stall", i), {15'd0, stall}, {15'd0, tbl[i].st});
            tick();
        end

        // RAW hazard on r5 (still busy from the table): write-back cycle, then the cycle after.
        drive(1'b1, 3'd5, 16'h1234, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        chk("haz_wr_rdata_a", rdata_a, BYP ? 16'h1234 : 16'h0000);
        chk("haz_wr_busy_a", {15'd0, busy_a}, BYP ? 16'h0000 : 16'h0001);
        chk("haz_wr_stall", {15'd0, stall}, BYP ? 16'h0000 : 16'h0001);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        chk("haz_after_rdata_a", rdata_a, 16'h1234);
        chk("haz_after_stall", {15'd0, stall}, 16'h0000);
        tick();

        // Write-back and re-issue of busy r6 on the same edge, read in that cycle.
        drive(1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6);
        #1;
        chk("coll_wr_rdata_a", rdata_a, BYP ? 16'h5A5A : 16'hABCD);
        chk("coll_wr_busy_a", {15'd0, busy_a}, 16'h0001);
        chk("coll_wr_stall", {15'd0, stall}, 16'h0001);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        chk("coll_after_rdata_a", rdata_a, 16'h5A5A);
        chk("coll_after_busy_b", {15'd0, busy_b}, 16'h0001);
        tick();

        // Randomized phase against the reference model, with occasional resets.
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            ea = 1'($urandom_range(0, 1));
            eb = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ea, eb,
                  1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
            #1;
            bx = exp_busy(raddr_a);
            by = exp_busy(raddr_b);
            chk("rnd_rdata_a", rdata_a, exp_rd(raddr_a));
            chk("rnd_rdata_b", rdata_b, exp_rd(raddr_b));
            chk("rnd_busy_a", {15'd0, busy_a}, {15'd0, bx});
            chk("rnd_busy_b", {15'd0, busy_b}, {15'd0, by});
            chk("rnd_stall", {15'd0, stall}, {15'd0, (ea & bx) | (eb & by)});
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
